// File: rtl/memory_bank.sv
// 128-bit line store behind the memory interface pins, with fixed-latency read return
// on a shared tri-state bus, access counters and sticky error flags.
module memory_bank #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic         mclk,
    input  logic         rst,
    input  logic [31:0]  mem_addr_sel,
    inout  wire  [127:0] mem_dat,
    input  logic         mem_en,
    input  logic         mem_we,
    input  logic         mem_re,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count,
    output logic         err_conflict,
    output logic         err_range
);

    localparam int LINES = 1 << ADDR_W;

    logic [127:0]        mem_q  [LINES];
    logic [127:0]        pipe_q [READ_LAT];
    logic [READ_LAT-1:0] vld_q, vld_d;
    logic [31:0]         rd_count_q, rd_count_d;
    logic [31:0]         wr_count_q, wr_count_d;
    logic                err_conflict_q, err_conflict_d;
    logic                err_range_q, err_range_d;

    logic [ADDR_W-1:0]   line_idx;
    logic                in_range;
    logic                wr, rd;
    logic [127:0]        rd_data;
    logic                unused_addr_lsb;

    assign line_idx        = mem_addr_sel[ADDR_W+3:4];
    assign in_range        = (mem_addr_sel[31:ADDR_W+4] == '0);
    assign unused_addr_lsb = ^mem_addr_sel[3:0];

    // A conflicting request (we and re together) falls into wr; rd excludes it.
    assign wr      = mem_en && mem_we;
    assign rd      = mem_en && mem_re && !mem_we;
    assign rd_data = in_range ? mem_q[line_idx] : '0;

    // Drive is gated by the live rd term so the bus drops the moment we rises.
    assign mem_dat = (vld_q[READ_LAT-1] && rd) ? pipe_q[READ_LAT-1] : {128{1'bz}};

    always_comb begin
        vld_d          = vld_q << 1;
        vld_d[0]       = rd;
        rd_count_d     = rd_count_q;
        wr_count_d     = wr_count_q;
        err_conflict_d = err_conflict_q;
        err_range_d    = err_range_q;

        if (wr) begin
            vld_d = '0;
            if (in_range) begin
                wr_count_d = wr_count_q + 32'd1;
            end
        end
        if (rd) begin
            rd_count_d = rd_count_q + 32'd1;
        end
        if (wr && mem_re) begin
            err_conflict_d = 1'b1;
        end
        if ((wr || rd) && !in_range) begin
            err_range_d = 1'b1;
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            vld_q          <= '0;
            rd_count_q     <= '0;
            wr_count_q     <= '0;
            err_conflict_q <= 1'b0;
            err_range_q    <= 1'b0;
        end else begin
            vld_q          <= vld_d;
            rd_count_q     <= rd_count_d;
            wr_count_q     <= wr_count_d;
            err_conflict_q <= err_conflict_d;
            err_range_q    <= err_range_d;
        end
    end

    // Array and pipeline data carry no reset; contents survive rst by design.
    always_ff @(posedge mclk) begin
        if (wr && in_range) begin
            mem_q[line_idx] <= mem_dat;
        end
        pipe_q[0] <= rd_data;
        for (int i = 1; i < READ_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rd_count     = rd_count_q;
    assign wr_count     = wr_count_q;
    assign err_conflict = err_conflict_q;
    assign err_range    = err_range_q;

endmodule

// File: tb/tb_memory_bank.sv
// Bench for memory_bank: READ_LAT=1 and READ_LAT=3 instances share stimulus and are checked
// every cycle against a line/history model, plus directed literal expectations.
module tb_memory_bank;

    logic         mclk = 1'b0;
    logic         rst  = 1'b1;
    logic [31:0]  addr;
    logic         en, we, re;
    logic [1:0]   tb_drv;
    logic [127:0] tb_dat;

    wire  [127:0] bus1, bus3;
    logic [31:0]  rdc1, wrc1, rdc3, wrc3;
    logic         ec1, er1, ec3, er3;

    int checks = 0;
    int errors = 0;

    always #5 mclk = ~mclk;

    assign bus1 = tb_drv[0] ? tb_dat : {128{1'bz}};
    assign bus3 = tb_drv[1] ? tb_dat : {128{1'bz}};

    memory_bank #(.ADDR_W(10), .READ_LAT(1)) u_lat1 (
        .mclk(mclk), .rst(rst), .mem_addr_sel(addr), .mem_dat(bus1),
        .mem_en(en), .mem_we(we), .mem_re(re),
        .rd_count(rdc1), .wr_count(wrc1), .err_conflict(ec1), .err_range(er1)
    );

    memory_bank #(.ADDR_W(10), .READ_LAT(3)) u_lat3 (
        .mclk(mclk), .rst(rst), .mem_addr_sel(addr), .mem_dat(bus3),
        .mem_en(en), .mem_we(we), .mem_re(re),
        .rd_count(rdc3), .wr_count(wrc3), .err_conflict(ec3), .err_range(er3)
    );

    // Model: line contents, counters, flags, and a history of the last few edges'
    // read captures (newest first). A LAT-N bank shows history entry N-1.
    typedef struct {
        bit           v;
        bit           k;
        logic [127:0] d;
    } ent_t;

    logic [127:0] mem_m [int];
    ent_t         hist [$];
    logic [31:0]  m_rd = '0;
    logic [31:0]  m_wr = '0;
    bit           m_ec = 1'b0;
    bit           m_er = 1'b0;
    bit           oor;
    int           ln;
    ent_t         e;

    always @(posedge mclk or posedge rst) begin
        if (rst) begin
            m_rd = '0;
            m_wr = '0;
            m_ec = 1'b0;
            m_er = 1'b0;
            hist.delete();
        end else begin
            oor = (addr >= 32'h0000_4000);
            ln  = int'(addr[13:4]);
            e   = '{v: 1'b0, k: 1'b0, d: '0};
            if (en && we) begin
                if (re) m_ec = 1'b1;
                if (oor) m_er = 1'b1;
                else begin
                    mem_m[ln] = tb_dat;
                    m_wr      = m_wr + 32'd1;
                end
                foreach (hist[j]) hist[j].v = 1'b0;
            end else if (en && re) begin
                m_rd = m_rd + 32'd1;
                if (oor) begin
                    m_er = 1'b1;
                    e    = '{v: 1'b1, k: 1'b1, d: '0};
                end else if (mem_m.exists(ln)) begin
                    e = '{v: 1'b1, k: 1'b1, d: mem_m[ln]};
                end else begin
                    e.v = 1'b1;
                end
            end
            hist.push_front(e);
            if (hist.size() > 4) void'(hist.pop_back());
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_bus(input string nm, input logic [127:0] bus, input int lat, input bit drv_tb);
        bit dut_drv;
        dut_drv = (hist.size() >= lat) && en && re && !we;
        if (dut_drv) dut_drv = hist[lat-1].v;
        if (dut_drv && !drv_tb && hist[lat-1].k) chk(nm, bus, hist[lat-1].d);
        else if (!dut_drv && drv_tb) chk(nm, bus, tb_dat);
    endtask

    always @(negedge mclk) begin
        chk("rd_count_l1", rdc1, m_rd);
        chk("wr_count_l1", wrc1, m_wr);
        chk("err_conflict_l1", ec1, m_ec);
        chk("err_range_l1", er1, m_er);
        chk("rd_count_l3", rdc3, m_rd);
        chk("wr_count_l3", wrc3, m_wr);
        chk("err_conflict_l3", ec3, m_ec);
        chk("err_range_l3", er3, m_er);
        chk_bus("bus_l1", bus1, 1, tb_drv[0]);
        chk_bus("bus_l3", bus3, 3, tb_drv[1]);
    end

    task automatic set_in(input bit e_i, input bit w_i, input bit r_i, input logic [31:0] a_i,
                          input bit d_i, input logic [127:0] dt_i);
        en     = e_i;
        we     = w_i;
        re     = r_i;
        addr   = a_i;
        tb_drv = {d_i, d_i};
        tb_dat = dt_i;
    endtask

    task automatic tick;
        @(posedge mclk);
        #2;
    endtask

    task automatic write_line(input logic [31:0] a, input logic [127:0] dt);
        set_in(1, 1, 0, a, 1, dt);
        tick;
    endtask

    task automatic idle;
        set_in(0, 0, 0, 32'h0, 0, '0);
        tick;
    endtask

    localparam logic [127:0] A5  = {16{8'hA5}};
    localparam logic [127:0] PAT = 128'h0123456789ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] RMW = 128'h0123456789ABCDEF_FEDCBA98_DEADBEEF;

    initial begin
        set_in(0, 0, 0, 32'h0, 0, '0);
        rst = 1'b1;
        tick;
        tick;
        chk("reset_rd_count", rdc1, 32'd0);
        chk("reset_wr_count", wrc1, 32'd0);
        chk("reset_err_conflict", ec1, 1'b0);
        chk("reset_err_range", er1, 1'b0);
        rst = 1'b0;
        tick;

        // Write then read, latency 1
        write_line(32'h40, A5);
        chk("t1_wr_count", wrc1, 32'd1);
        set_in(1, 0, 1, 32'h40, 0, '0);
        tick;
        chk("t1_rd_count", rdc1, 32'd1);
        #1 chk("t1_read_data", bus1, A5);
        idle;

        // Read-modify-write on line 0x10
        write_line(32'h10, PAT);
        set_in(1, 0, 1, 32'h10, 0, '0);
        tick;
        tick;
        set_in(1, 1, 0, 32'h10, 1, {PAT[127:32], 32'hDEADBEEF});
        tick;
        tick;
        set_in(1, 0, 1, 32'h10, 0, '0);
        tick;
        #1 chk("t2_rmw_data", bus1, RMW);
        chk("t2_wr_count", wrc1, 32'd4);
        idle;

        // Back-to-back reads, latency 3
        write_line(32'h00, 128'd1);
        write_line(32'h10, 128'd2);
        write_line(32'h20, 128'd3);
        set_in(1, 0, 1, 32'h00, 0, '0);
        tick;
        set_in(1, 0, 1, 32'h10, 0, '0);
        tick;
        set_in(1, 0, 1, 32'h20, 0, '0);
        tick;
        set_in(1, 0, 1, 32'h00, 0, '0);
        #1 chk("t3_lat3_first", bus3, 128'd1);
        tick;
        #1 chk("t3_lat3_second", bus3, 128'd2);
        tick;
        #1 chk("t3_lat3_third", bus3, 128'd3);
        idle;
        chk("t3_rd_count", rdc3, 32'd9);

        // Out-of-range write and read
        chk("t4_err_range_before", er1, 1'b0);
        write_line(32'h0001_0000, {128{1'b1}});
        chk("t4_err_range", er1, 1'b1);
        chk("t4_wr_count", wrc1, 32'd7);
        set_in(1, 0, 1, 32'h0001_0000, 0, '0);
        tick;
        #1 chk("t4_oor_read_zero", bus1, 128'd0);
        set_in(1, 0, 1, 32'h00, 0, '0);
        tick;
        #1 chk("t4_line0_unchanged", bus1, 128'd1);
        idle;

        // Conflict while a latency-3 read is draining
        set_in(1, 0, 1, 32'h20, 0, '0);
        tick;
        tick;
        tick;
        set_in(1, 1, 1, 32'h50, 1, 128'd1);
        #1 chk("t5_bus_l1_not_driven", bus1, 128'd1);
        chk("t5_bus_l3_not_driven", bus3, 128'd1);
        tick;
        chk("t5_err_conflict", ec1, 1'b1);
        chk("t5_rd_count", rdc1, 32'd14);
        set_in(1, 0, 1, 32'h50, 0, '0);
        tick;
        tb_drv = 2'b10;
        tb_dat = '0;
        #1 chk("t5_line5", bus1, 128'd1);
        chk("t5_lat3_stale_dropped", bus3, 128'd0);
        idle;

        // Reset in the middle of a read return
        set_in(1, 0, 1, 32'h50, 0, '0);
        tick;
        #1 chk("t6_driven_before_rst", bus1, 128'd1);
        rst    = 1'b1;
        tb_drv = 2'b11;
        tb_dat = '0;
        #1 chk("t6_bus_released", bus1, 128'd0);
        chk("t6_rd_count", rdc1, 32'd0);
        chk("t6_wr_count", wrc1, 32'd0);
        chk("t6_err_conflict", ec1, 1'b0);
        chk("t6_err_range", er1, 1'b0);
        tick;
        rst = 1'b0;
        idle;
        set_in(1, 0, 1, 32'h40, 0, '0);
        tick;
        #1 chk("t6_data_persists", bus1, A5);
        chk("t6_rd_count_after", rdc1, 32'd1);
        idle;
        idle;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/memory_bank.md
Name: memory_bank

Overview:
- Synchronous 128-bit-wide backing store on the far side of the memory interface's mem_* pins.
- Accepts line reads and writes from the interface over a shared tri-state data bus.
- Returns read data with a configurable fixed latency.
- Keeps access counters and sticky error flags for debug and bring-up.
- Sits directly downstream of the memory interface, clocked on the same memory clock.

Parameters:
ADDR_W, 10, log2 of number of 128-bit lines (default 1024 lines = 16 KiB)
READ_LAT, 1, edges from read sample to mem_dat driven; legal range 1..4

Ports:
mclk  input  1  memory clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
mem_addr_sel  input  32  byte address; line index = [ADDR_W+3:4], bits [3:0] ignored
mem_dat  inout  128  shared data bus; driven by this block only during read return
mem_en  input  1  bank enable
mem_we  input  1  write enable (qualified by mem_en)
mem_re  input  1  read enable (qualified by mem_en)
rd_count  output  32  reads accepted since reset, wraps at 2^32
wr_count  output  32  writes committed since reset, wraps at 2^32
err_conflict  output  1  sticky: mem_en && mem_we && mem_re sampled
err_range  output  1  sticky: access with mem_addr_sel[31:ADDR_W+4] != 0

Behaviour:
- Reset (async, rst=1):
  - Read pipeline valid bits cleared; mem_dat released to Z.
  - rd_count=0, wr_count=0, err_conflict=0, err_range=0.
  - Array contents are NOT cleared; they persist across reset.
- Access decode, sampled each rising edge:
  - wr = en && we.
  - rd = en && re && !we.
  - idle otherwise, including en=0 with we/re high.
- Write, edge k with wr:
  - If in range, array[line] <= mem_dat and wr_count++.
  - If out of range, array unchanged, wr_count unchanged, err_range <= 1.
  - A write repeats on every edge wr holds; each repeat counts.
- Read, edge k with rd:
  - Row is captured into a READ_LAT-deep pipeline; rd_count++.
  - If out of range, the captured data is 128'h0 and err_range <= 1.
- Read return:
  - The pipeline output stage becomes valid after edge k+READ_LAT-1.
  - mem_dat drives the output stage while that stage is valid AND current en && re && !we.
  - Otherwise mem_dat is Z.
  - With READ_LAT=1, the master presenting en/re/addr before edge k samples correct data at edge k+1.
- Back-to-back reads:
  - One read is accepted per edge; the pipeline is fully pipelined.
  - The driven value always corresponds to the address sampled READ_LAT edges earlier.
- Read-after-write: a read sampled at edge k+1 after a write at edge k to the same line returns the new data. No bypass is needed because the write commits at edge k.
- Conflict (en && we && re):
  - Treated as a write; the read is suppressed (no pipeline entry, no rd_count increment).
  - err_conflict <= 1.
  - The bus is never driven while we=1, including during drain of earlier reads.
- Transition read -> write (re falls and we rises on the same edge):
  - The drive enable drops combinationally with we, so there is no bus contention with the writer.
  - Pipelined read entries still in flight are discarded and never driven.
- Reset mid-read: pipeline valid bits clear immediately and the bus releases Z in the same cycle.
- Counters wrap silently from 32'hFFFFFFFF to 0.
- Sticky flags clear only on rst.

Test Plan:
1. Write then read, in range, READ_LAT=1: addr=0x40, drive mem_dat=128'hA5..A5 with en=we=1 for one edge, then en=re=1 addr=0x40 -> mem_dat=128'hA5..A5 at next edge; wr_count=1, rd_count=1.
2. Read-modify-write sequence matching the interface (re 2 cycles, then we 2 cycles, data low 32 bits replaced with 32'hDEADBEEF on line 0x10) -> subsequent read of 0x10 returns upper 96 bits unchanged, [31:0]=32'hDEADBEEF; wr_count=2 (repeat write counted).
3. Back-to-back reads, READ_LAT=3, addrs 0x00, 0x10, 0x20 on consecutive edges with lines preloaded 1, 2, 3 -> mem_dat shows 1, 2, 3 on edges 3, 4, 5 after the first sample.
4. Out of range, ADDR_W=10: write to 0x0001_0000 -> array unchanged, err_range=1, wr_count=0; read of the same address -> returns 128'h0.
5. Conflict: en=we=re=1 with data 128'h1 at line 5 -> line 5 = 1, err_conflict=1, rd_count unchanged, mem_dat never driven (no X on bus).
6. Reset mid-read: assert rst while mem_dat is driven -> mem_dat Z in the same cycle, counters and flags 0; array data written before the reset is still readable afterwards.
